// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device clock falls and samples the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int MAX_HOLD   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_CYCLES = (MAX_HOLD > TIMEOUT_CYCLES) ? MAX_HOLD : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE, FINISH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;
    logic             drive;
    logic             clk_p0, clk_p1, clk_p2;
    logic             data_p0, data_p1;
    logic             fall, accept, watched, expired, timeout_fire, lines_high;

    assign fall       = clk_p2 & ~clk_p1;
    assign accept     = tx_valid & tx_ready;
    assign watched    = (state == SEND) || (state == WAIT_IDLE);
    assign lines_high = clk_p1 & data_p1;
    // A device fall in the same cycle as expiry wins and restarts the window.
    assign expired    = watched && !fall && (cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt    = state;
        timeout_fire = 1'b0;
        case (state)
            IDLE:    if (tx_valid) state_nxt = INHIBIT;
            INHIBIT: if (cnt == INHIBIT_LAST) state_nxt = REQ;
            REQ:     if (cnt == REQ_LAST) state_nxt = SEND;
            SEND: begin
                if (fall && bit_cnt == 4'd10) begin
                    state_nxt = WAIT_IDLE;
                end else if (expired) begin
                    state_nxt    = FINISH;
                    timeout_fire = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (lines_high) begin
                    state_nxt = FINISH;
                end else if (expired) begin
                    state_nxt    = FINISH;
                    timeout_fire = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0/p1 synchronise the pins; p2 keeps the previous clock level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            drive       <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            clk_p0      <= 1'b1;
            clk_p1      <= 1'b1;
            clk_p2      <= 1'b1;
            data_p0     <= 1'b1;
            data_p1     <= 1'b1;
        end else begin
            state <= state_nxt;
            {clk_p2, clk_p1, clk_p0} <= {clk_p1, clk_p0, ps2_clk_in};
            {data_p1, data_p0}       <= {data_p0, ps2_data_in};

            if (state_nxt != state || state == IDLE || (watched && fall))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (accept) begin
                ack_err     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (timeout_fire)
                timeout_err <= 1'b1;

            if (state == REQ) begin
                bit_cnt <= '0;
                drive   <= 1'b1;
            end else if (state == SEND && fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd10)
                    ack_err <= data_p1;
                else
                    drive <= ~frame[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            frame <= {1'b1, ~^tx_data, tx_data};
        else if (state == SEND && fall)
            frame <= {1'b0, frame[9:1]};
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = (state == REQ) || (state == SEND && drive);
    assign done        = (state == FINISH);

endmodule
